// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store sequencer: access modes, FSM states
// and the mode-to-byte-count helper.
package lsu_pkg;

    localparam logic [2:0] BYTE              = 3'b000;
    localparam logic [2:0] HALFWORD          = 3'b001;
    localparam logic [2:0] WORD              = 3'b010;
    localparam logic [2:0] BYTE_UNSIGNED     = 3'b011;
    localparam logic [2:0] HALFWORD_UNSIGNED = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_e;

    // Number of byte transfers for a mode; illegal modes are rejected before use.
    function automatic logic [2:0] mode_nbytes(input logic [2:0] mode);
        case (mode)
            BYTE, BYTE_UNSIGNED:         mode_nbytes = 3'd1;
            HALFWORD, HALFWORD_UNSIGNED: mode_nbytes = 3'd2;
            WORD:                        mode_nbytes = 3'd4;
            default:                     mode_nbytes = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational sign/zero extension of the assembled load bytes by access mode.
module load_extend (
    input  logic [31:0] i_acc,
    input  logic [2:0]  i_mode,
    output logic [31:0] o_data
);
    import lsu_pkg::*;

    always_comb begin
        o_data = i_acc;
        case (i_mode)
            BYTE:              o_data = {{24{i_acc[7]}}, i_acc[7:0]};
            HALFWORD:          o_data = {{16{i_acc[15]}}, i_acc[15:0]};
            BYTE_UNSIGNED:     o_data = {24'h0, i_acc[7:0]};
            HALFWORD_UNSIGNED: o_data = {16'h0, i_acc[15:0]};
            default:           o_data = i_acc;
        endcase
    end

endmodule

// File: rtl/lsu_seq_ctrl.sv
// Big-endian byte-serial load/store sequencer for a byte-wide data memory.
// Optional MISALIGN_TRAP_EN rejects misaligned halfword/word accesses.
module lsu_seq_ctrl #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned MEM_BYTES = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_mode,
    input  logic [31:0]       req_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);
    import lsu_pkg::*;

    localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_BYTES);

    state_e            r_state;
    state_e            w_state_next;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_mode;
    logic [31:0]       r_wdata;
    logic [2:0]        r_nbytes;
    logic [1:0]        r_cnt;
    logic [23:0]       r_acc;
    logic [31:0]       r_rdata;
    logic              r_done;
    logic              r_err;

    logic [2:0]        w_nbytes;
    logic [ADDR_W-1:0] w_last_addr;
    logic              w_misalign;
    logic              w_reject;
    logic              w_last;
    logic [1:0]        w_byte_idx;
    logic [31:0]       w_acc_next;
    logic [31:0]       w_ext;

    // Accept-time request qualification
    assign w_nbytes    = mode_nbytes(req_mode);
    assign w_last_addr = req_addr + ADDR_W'(w_nbytes) - ADDR_W'(1);

`ifdef MISALIGN_TRAP_EN
    assign w_misalign = (((req_mode == HALFWORD) || (req_mode == HALFWORD_UNSIGNED)) && req_addr[0])
                      || ((req_mode == WORD) && (req_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // Both ends are checked so that an access wrapping past 2^ADDR_W is also rejected
    assign w_reject = (req_mode > HALFWORD_UNSIGNED) || (req_addr >= MEM_LIMIT)
                    || (w_last_addr >= MEM_LIMIT) || w_misalign;

    assign w_last     = ({1'b0, r_cnt} == (r_nbytes - 3'd1));
    assign w_byte_idx = 2'(r_nbytes - 3'd1 - {1'b0, r_cnt});
    assign w_acc_next = {r_acc, mem_rdata};

    load_extend u_load_extend (
        .i_acc  (w_acc_next),
        .i_mode (r_mode),
        .o_data (w_ext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // Next state and memory-side strobes
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b1;
        mem_addr     = '0;
        mem_re       = 1'b0;
        mem_we       = 1'b0;
        mem_wdata    = 8'h00;
        case (r_state)
            IDLE: begin
                busy = req;
                if (req) w_state_next = w_reject ? DONE : XFER;
            end
            XFER: begin
                mem_addr = r_addr + ADDR_W'(r_cnt);
                if (r_we) begin
                    mem_we    = 1'b1;
                    mem_wdata = r_wdata[{w_byte_idx, 3'b000} +: 8];
                end else begin
                    mem_re = 1'b1;
                end
                if (w_last) w_state_next = DONE;
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Request latch, byte counter, load assembly and registered responses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_mode   <= 3'b000;
            r_wdata  <= 32'h0;
            r_nbytes <= 3'd0;
            r_cnt    <= 2'd0;
            r_acc    <= 24'h0;
            r_rdata  <= 32'h0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req) begin
                        r_we     <= req_we;
                        r_addr   <= req_addr;
                        r_mode   <= req_mode;
                        r_wdata  <= req_wdata;
                        r_nbytes <= w_nbytes;
                        r_cnt    <= 2'd0;
                        r_acc    <= 24'h0;
                        r_done   <= w_reject;
                        r_err    <= w_reject;
                    end
                end
                XFER: begin
                    if (!r_we) r_acc <= w_acc_next[23:0];
                    if (w_last) begin
                        r_done <= 1'b1;
                        if (!r_we) r_rdata <= w_ext;
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                DONE:    r_err <= 1'b0;
                default: r_err <= 1'b0;
            endcase
        end
    end

    assign done  = r_done;
    assign err   = r_err;
    assign rdata = r_rdata;

endmodule

// File: tb/tb_lsu_seq_ctrl.sv
// Directed bench for lsu_seq_ctrl with a small byte memory model and strobe logger.
module tb_lsu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [2:0]  req_mode = 3'b000;
    logic [31:0] req_wdata = 32'h0;
    logic        busy, done, err;
    logic [31:0] rdata;
    logic [31:0] mem_addr;
    logic        mem_re, mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    lsu_seq_ctrl #(.ADDR_W(32), .MEM_BYTES(1000)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_mode  (req_mode),
        .req_wdata (req_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory: fixed preload at 0x10..0x15, writable array elsewhere; strobe log
    logic [7:0]  wmem [0:1023];
    int          re_cnt = 0;
    int          we_cnt = 0;
    logic [31:0] re_log [0:63];
    logic [31:0] we_alog [0:63];
    logic [7:0]  we_dlog [0:63];

    always_comb begin
        case (mem_addr)
            32'h10:  mem_rdata = 8'h80;
            32'h11:  mem_rdata = 8'h01;
            32'h12:  mem_rdata = 8'h02;
            32'h13:  mem_rdata = 8'h03;
            32'h14:  mem_rdata = 8'h04;
            32'h15:  mem_rdata = 8'h05;
            default: mem_rdata = wmem[mem_addr[9:0]];
        endcase
    end

    always @(posedge clk) begin
        if (mem_re) begin
            re_log[re_cnt[5:0]] <= mem_addr;
            re_cnt <= re_cnt + 1;
        end
        if (mem_we) begin
            wmem[mem_addr[9:0]]  <= mem_wdata;
            we_alog[we_cnt[5:0]] <= mem_addr;
            we_dlog[we_cnt[5:0]] <= mem_wdata;
            we_cnt <= we_cnt + 1;
        end
    end

    int          lat;
    int          re0, we0;
    logic [31:0] obs_rdata;
    logic        obs_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, hold it until done, record latency and response
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [2:0] mode,
                          input logic [31:0] wd);
        logic got;
        @(negedge clk);
        req = 1'b1; req_we = we; req_addr = addr; req_mode = mode; req_wdata = wd;
        re0 = re_cnt; we0 = we_cnt;
        #1 chk("busy_on_accept", 32'(busy), 32'd1);
        lat = 0; got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); lat++;
            @(negedge clk);
            if (done) got = 1'b1;
        end
        obs_rdata = rdata; obs_err = err;
        req = 1'b0;
        chk("done_seen", 32'(got), 32'd1);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("err_clears", 32'(err), 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_mem_re", 32'(mem_re), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        rst = 1'b0;

        // WORD load @0x10
        do_req(1'b0, 32'h10, 3'b010, 32'h0);
        chk("w_lat", 32'(lat), 32'd5);
        chk("w_rdata", obs_rdata, 32'h80010203);
        chk("w_err", 32'(obs_err), 32'd0);
        chk("w_nre", 32'(re_cnt - re0), 32'd4);
        chk("w_nwe", 32'(we_cnt - we0), 32'd0);
        for (int i = 0; i < 4; i++) chk("w_raddr", re_log[6'(re0 + i)], 32'h10 + 32'(i));

        // BYTE / BYTE_UNSIGNED @0x10
        do_req(1'b0, 32'h10, 3'b000, 32'h0);
        chk("b_lat", 32'(lat), 32'd2);
        chk("b_rdata", obs_rdata, 32'hFFFFFF80);
        do_req(1'b0, 32'h10, 3'b011, 32'h0);
        chk("bu_rdata", obs_rdata, 32'h00000080);

        // HALFWORD @0x11 (misaligned)
        do_req(1'b0, 32'h11, 3'b001, 32'h0);
`ifdef MISALIGN_TRAP_EN
        chk("h11_err", 32'(obs_err), 32'd1);
        chk("h11_nre", 32'(re_cnt - re0), 32'd0);
`else
        chk("h11_lat", 32'(lat), 32'd3);
        chk("h11_rdata", obs_rdata, 32'h00000102);
        chk("h11_err", 32'(obs_err), 32'd0);
`endif

        // HALFWORD_UNSIGNED and HALFWORD @0x10
        do_req(1'b0, 32'h10, 3'b100, 32'h0);
        chk("hu_rdata", obs_rdata, 32'h00008001);
        do_req(1'b0, 32'h10, 3'b001, 32'h0);
        chk("h_rdata", obs_rdata, 32'hFFFF8001);

        // HALFWORD store @0x20, MSB first, rdata untouched
        do_req(1'b1, 32'h20, 3'b001, 32'h1234ABCD);
        chk("hs_lat", 32'(lat), 32'd3);
        chk("hs_nwe", 32'(we_cnt - we0), 32'd2);
        chk("hs_nre", 32'(re_cnt - re0), 32'd0);
        chk("hs_a0", we_alog[6'(we0)], 32'h20);
        chk("hs_d0", 32'(we_dlog[6'(we0)]), 32'hAB);
        chk("hs_a1", we_alog[6'(we0 + 1)], 32'h21);
        chk("hs_d1", 32'(we_dlog[6'(we0 + 1)]), 32'hCD);
        chk("hs_rdata_kept", obs_rdata, 32'hFFFF8001);

        // Read the stored halfword back
        do_req(1'b0, 32'h20, 3'b001, 32'h0);
        chk("hrb_rdata", obs_rdata, 32'hFFFFABCD);

        // Illegal mode
        do_req(1'b0, 32'h10, 3'b110, 32'h0);
        chk("bad_lat", 32'(lat), 32'd1);
        chk("bad_err", 32'(obs_err), 32'd1);
        chk("bad_nre", 32'(re_cnt - re0), 32'd0);
        chk("bad_rdata_kept", obs_rdata, 32'hFFFFABCD);

        // Out of range: last byte past the end, wrap past 2^32, and the last legal byte
        do_req(1'b0, 32'd998, 3'b010, 32'h0);
        chk("oor_lat", 32'(lat), 32'd1);
        chk("oor_err", 32'(obs_err), 32'd1);
        chk("oor_nre", 32'(re_cnt - re0), 32'd0);
        do_req(1'b1, 32'hFFFFFFFE, 3'b010, 32'h0);
        chk("wrap_err", 32'(obs_err), 32'd1);
        chk("wrap_nwe", 32'(we_cnt - we0), 32'd0);
        do_req(1'b1, 32'd999, 3'b000, 32'h000000A5);
        chk("edge_err", 32'(obs_err), 32'd0);
        chk("edge_nwe", 32'(we_cnt - we0), 32'd1);
        chk("edge_a", we_alog[6'(we0)], 32'd999);
        chk("edge_d", 32'(we_dlog[6'(we0)]), 32'hA5);

        // WORD load @0x12 (misaligned)
        do_req(1'b0, 32'h12, 3'b010, 32'h0);
`ifdef MISALIGN_TRAP_EN
        chk("w12_err", 32'(obs_err), 32'd1);
        chk("w12_nre", 32'(re_cnt - re0), 32'd0);
`else
        chk("w12_err", 32'(obs_err), 32'd0);
        chk("w12_nre", 32'(re_cnt - re0), 32'd4);
        chk("w12_a0", re_log[6'(re0)], 32'h12);
        chk("w12_a3", re_log[6'(re0 + 3)], 32'h15);
        chk("w12_rdata", obs_rdata, 32'h02030405);
`endif

        // Reset during the second XFER cycle of a WORD store
        @(negedge clk);
        req = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_mode = 3'b010; req_wdata = 32'hDEADBEEF;
        we0 = we_cnt;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; req = 1'b0;
        #1;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_mem_we", 32'(mem_we), 32'd0);
        chk("mrst_mem_addr", mem_addr, 32'h0);
        chk("mrst_mem_wdata", 32'(mem_wdata), 32'h0);
        chk("mrst_rdata", rdata, 32'h0);
        chk("mrst_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        chk("mrst_nwe", 32'(we_cnt - we0), 32'd1);
        chk("mrst_first_byte", 32'(we_dlog[6'(we0)]), 32'hDE);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("mrst_nwe_after", 32'(we_cnt - we0), 32'd1);

        do_req(1'b0, 32'h10, 3'b000, 32'h0);
        chk("post_rst_lat", 32'(lat), 32'd2);
        chk("post_rst_rdata", obs_rdata, 32'hFFFFFF80);
        chk("post_rst_err", 32'(obs_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_seq_ctrl.md
Name: lsu_seq_ctrl

Overview:
Load/store sequencer between the pipeline's memory stage and a byte-wide, single-port data memory (one byte per cycle, asynchronous read, synchronous write).
- Accepts one request at a time and issues 1/2/4 consecutive byte transfers.
- Byte order is big-endian: the lowest address holds the MSB.
- For loads, assembles the bytes into a 32-bit value with sign or zero extension.
- Holds the pipeline stalled until the access completes.

Parameters:
ADDR_W, 32, width of byte address
MEM_BYTES, 1000, memory size in bytes; accesses with any byte at address >= MEM_BYTES raise err

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
req  in  1  access request from memory stage; held until done
req_we  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  byte address of first (MSB) byte
req_mode  in  3  access mode: 000 BYTE, 001 HALFWORD, 010 WORD, 011 BYTE_UNSIGNED, 100 HALFWORD_UNSIGNED
req_wdata  in  32  store data; low 8/16/32 bits are used
busy  out  1  controller not idle; pipeline stall
done  out  1  one-cycle completion pulse
err  out  1  valid with done; access rejected, no memory cycle performed
rdata  out  32  load result; held from done until next accept
mem_addr  out  ADDR_W  byte address to memory
mem_re  out  1  byte read strobe
mem_we  out  1  byte write strobe
mem_wdata  out  8  byte to write
mem_rdata  in  8  byte read, valid in the same cycle as mem_re

Behaviour:
- Reset (asynchronous, rst=1):
  - State goes to IDLE.
  - busy, done, err, mem_re and mem_we are 0.
  - rdata, mem_addr and mem_wdata are 32'h0 / 0.
  - Byte counter and assembly register are cleared.
  - Reset mid-transfer abandons the access; no further strobes are issued.
- State machine: IDLE -> XFER -> DONE -> IDLE.
- IDLE:
  - On req=1, latch we, addr, mode and wdata.
  - Set n_bytes: 1 for BYTE/BU, 2 for HALFWORD/HU, 4 for WORD.
  - Go to XFER with cnt=0.
  - If req_mode is 101-111 or the address is out of range, go directly to DONE with err=1 and no strobes.
- XFER: one byte per cycle.
  - mem_addr = addr + cnt.
  - Load: mem_re=1 and acc = {acc[23:0], mem_rdata}.
  - Store: mem_we=1 and mem_wdata = byte (n_bytes-1-cnt) of wdata, so the MSB goes first.
  - When cnt == n_bytes-1, go to DONE; otherwise cnt++.
- DONE:
  - done=1 for exactly one cycle; err=1 if the request was rejected.
  - Load: rdata is updated with the extended acc. Store: rdata is unchanged.
  - Next state is IDLE.
- Extension: BYTE sign-extends acc[7:0], HALFWORD sign-extends acc[15:0], BU/HU zero-extend, WORD passes acc through.
- Latency from the accept edge to the done pulse is n_bytes+1 cycles; an err response takes 1 cycle.
- busy=1 in XFER and DONE, and in IDLE while req=1 (combinational stall on the accept cycle).
- A new request cannot be accepted in the DONE cycle; the earliest accept is the cycle after done. The pipeline drops req in the cycle it samples done.
- req is ignored outside IDLE; request inputs are sampled only at accept.
- Address arithmetic wraps modulo 2^ADDR_W. The range check applies to addr+n_bytes-1.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: HALFWORD/HU with addr[0]!=0, or WORD with addr[1:0]!=0, is rejected at accept (DONE with err=1, no strobes).
- Undefined: misaligned accesses are performed byte by byte like any other access.

Decomposition:
- Package lsu_pkg:
  - Mode constants BYTE, HALFWORD, WORD, BYTE_UNSIGNED, HALFWORD_UNSIGNED, shared with the data memory.
  - State enum state_e {IDLE, XFER, DONE}.
  - Function mode_nbytes(mode).
- Sub-module load_extend: purely combinational acc + mode -> 32-bit extended result.

Test Plan:
- mem[0x10..0x13]=80,01,02,03; WORD load @0x10 -> exactly 4 mem_re cycles at addresses 0x10-0x13, done 5 cycles after accept, rdata=0x80010203, err=0.
- BYTE load @0x10 -> rdata=0xFFFFFF80. BYTE_UNSIGNED load @0x10 -> 0x00000080. HALFWORD load @0x11 -> 0x00000102 (macro off).
- HALFWORD store wdata=0x1234ABCD @0x20 -> two mem_we cycles: 0x20<=AB, 0x21<=CD; rdata unchanged.
- req_mode=3'b110, or WORD @ MEM_BYTES-2 -> done+err the cycle after accept, zero strobes.
- Assert rst during the 2nd XFER cycle of a WORD store -> all outputs 0 immediately, no further mem_we; the next request completes normally.
- With MISALIGN_TRAP_EN: WORD load @0x12 -> err=1, no mem_re. Without it: 4 reads at 0x12-0x15.
